// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage initiator for the data memory interface. Accepts one load or
// store request from the pipeline and drives the word address, byte enables,
// lane-aligned store data and the store strobe. It then waits for the memory to
// complete the access and returns either sign/zero-extended load data or a store
// acknowledge. Only one request is outstanding at a time. Misaligned accesses,
// illegal funct3 codes and timed-out accesses complete with an error.
//
// Parameters
//   TIMEOUT_CYCLES : number of cycles spent in LOAD/STORE with no completion
//                    before the access is aborted with an error
//
// Ports
//   i_clk                 rising-edge clock
//   i_rst_n               asynchronous active-low reset
//   i_req_valid           pipeline request valid
//   o_req_ready           unit can accept a request (state IDLE)
//   i_req_is_store        1 = store, 0 = load
//   i_req_funct3          RV32 funct3 (B/H/W/BU/HU)
//   i_req_address         byte address
//   i_req_store_data      store value, LSB-aligned
//   o_resp_valid          one-cycle completion pulse
//   o_resp_error          error flag, valid with o_resp_valid
//   o_resp_data           extended load result (0 for stores and errors)
//   o_mem_address         word-aligned address, held for the whole access
//   o_mem_store_data      store data shifted into its byte lanes
//   o_mem_byte_enable     byte lanes written
//   o_mem_store_valid     store strobe (memory triggers on its rising edge)
//   i_mem_load_data       word read data
//   i_mem_load_data_valid read data valid
//   i_mem_store_complete  one-cycle write-done pulse
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_is_store,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_address,
   input  logic [31:0] i_req_store_data,
   output logic        o_resp_valid,
   output logic        o_resp_error,
   output logic [31:0] o_resp_data,
   output logic [31:0] o_mem_address,
   output logic [31:0] o_mem_store_data,
   output logic [3:0]  o_mem_byte_enable,
   output logic        o_mem_store_valid,
   input  logic [31:0] i_mem_load_data,
   input  logic        i_mem_load_data_valid,
   input  logic        i_mem_store_complete
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LP_LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_resp_valid;
   logic          r_resp_error;
   logic [31:0]   r_resp_data;
   logic [31:0]   r_mem_address;
   logic [31:0]   r_mem_store_data;
   logic [3:0]    r_mem_byte_enable;
   logic          r_mem_store_valid;
   logic [1:0]    r_offset;
   logic [2:0]    r_funct3;
   logic [CW-1:0] r_timeout_count;

   logic          w_accept;
   logic          w_illegal;
   logic          w_misaligned;
   logic [1:0]    w_offset;
   logic [3:0]    w_byte_enable;
   logic [31:0]   w_store_data;
   logic [31:0]   w_lane;
   logic [31:0]   w_load_result;
   logic          w_timeout;

   assign o_req_ready       = (r_state == S_IDLE);
   assign o_resp_valid      = r_resp_valid;
   assign o_resp_error      = r_resp_error;
   assign o_resp_data       = r_resp_data;
   assign o_mem_address     = r_mem_address;
   assign o_mem_store_data  = r_mem_store_data;
   assign o_mem_byte_enable = r_mem_byte_enable;
   assign o_mem_store_valid = r_mem_store_valid;

   assign w_accept  = i_req_valid && (r_state == S_IDLE);
   assign w_offset  = i_req_address[1:0];
   assign w_timeout = (r_timeout_count == LP_LAST_COUNT);

   // Request classification. funct3[1:0] encodes the access size for both
   // loads and stores (00 byte, 01 half, 10 word); funct3[2] is the unsigned
   // flag and is only legal on byte/half loads.
   always_comb begin
      w_illegal     = 1'b0;
      w_misaligned  = 1'b0;
      w_byte_enable = 4'b1111;
      if (i_req_is_store) begin
         w_illegal = (i_req_funct3 > 3'b010);
      end else begin
         w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                     (i_req_funct3 == 3'b111);
      end
      case (i_req_funct3[1:0])
         2'b00: begin
            w_byte_enable = 4'b0001 << w_offset;
         end
         2'b01: begin
            w_misaligned  = w_offset[0];
            w_byte_enable = 4'b0011 << w_offset;
         end
         default: begin
            w_misaligned  = (w_offset != 2'b00);
            w_byte_enable = 4'b1111;
         end
      endcase
   end

   assign w_store_data = i_req_store_data << {w_offset, 3'b000};

   // Bring the addressed lane down to bit 0, then extend by access type.
   assign w_lane = i_mem_load_data >> {r_offset, 3'b000};

   always_comb begin
      w_load_result = w_lane;
      case (r_funct3)
         3'b000:  w_load_result = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_load_result = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_load_result = {24'd0, w_lane[7:0]};
         3'b101:  w_load_result = {16'd0, w_lane[15:0]};
         default: w_load_result = w_lane;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state           <= S_IDLE;
         r_resp_valid      <= 1'b0;
         r_resp_error      <= 1'b0;
         r_resp_data       <= 32'd0;
         r_mem_address     <= 32'd0;
         r_mem_store_data  <= 32'd0;
         r_mem_byte_enable <= 4'd0;
         r_mem_store_valid <= 1'b0;
         r_offset          <= 2'd0;
         r_funct3          <= 3'd0;
         r_timeout_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_illegal || w_misaligned) begin
                     // Rejected requests leave the memory-side outputs alone.
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b1;
                     r_resp_data  <= 32'd0;
                     r_state      <= S_RESP;
                  end else begin
                     r_mem_address   <= {i_req_address[31:2], 2'b00};
                     r_offset        <= w_offset;
                     r_funct3        <= i_req_funct3;
                     r_timeout_count <= '0;
                     if (i_req_is_store) begin
                        r_mem_byte_enable <= w_byte_enable;
                        r_mem_store_data  <= w_store_data;
                        r_mem_store_valid <= 1'b1;
                        r_state           <= S_STORE;
                     end else begin
                        r_state <= S_LOAD;
                     end
                  end
               end
            end

            S_LOAD: begin
               // A completion arriving on the expiry cycle takes priority.
               if (i_mem_load_data_valid) begin
                  r_resp_valid <= 1'b1;
                  r_resp_error <= 1'b0;
                  r_resp_data  <= w_load_result;
                  r_state      <= S_RESP;
               end else if (w_timeout) begin
                  r_resp_valid <= 1'b1;
                  r_resp_error <= 1'b1;
                  r_resp_data  <= 32'd0;
                  r_state      <= S_RESP;
               end else begin
                  r_timeout_count <= r_timeout_count + 1'b1;
               end
            end

            S_STORE: begin
               if (i_mem_store_complete) begin
                  r_mem_store_valid <= 1'b0;
                  r_resp_valid      <= 1'b1;
                  r_resp_error      <= 1'b0;
                  r_resp_data       <= 32'd0;
                  r_state           <= S_RESP;
               end else if (w_timeout) begin
                  r_mem_store_valid <= 1'b0;
                  r_resp_valid      <= 1'b1;
                  r_resp_error      <= 1'b1;
                  r_resp_data       <= 32'd0;
                  r_state           <= S_RESP;
               end else begin
                  r_timeout_count <= r_timeout_count + 1'b1;
               end
            end

            S_RESP: begin
               // Response is a single-cycle pulse; the IDLE cycle that
               // follows keeps the strobe low for two cycles between stores.
               r_resp_valid <= 1'b0;
               r_resp_error <= 1'b0;
               r_resp_data  <= 32'd0;
               r_state      <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
